// File: rtl/seq_counter_checker_pkg.sv
// Shared types and limits for the counter-stream checker.
// No timing of its own; used by the checker and its saturating counters.
package seq_counter_checker_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_counter_checker_if.sv
// Sample bus from a counter source into the checker: in_valid qualifies in_data.
// No ready signal; the checker accepts a sample every cycle.
interface seq_counter_checker_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/seq_counter_checker_sat_counter8.sv
// 8-bit counter that sticks at its maximum; clr beats inc, rst beats both.
// Count is registered: it reflects inc/clr one cycle later; never stalls.
module sat_counter8
  import seq_counter_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_counter_checker.sv
// Checks that each valid sample is the previous one plus one (mod 2^WIDTH).
// All outputs registered, one cycle after the capturing edge; no backpressure.
module seq_counter_checker
  import seq_counter_checker_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LOCK_N  = 4,
  parameter int MAX_ERR = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  seq_counter_checker_if.slave  smp,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  fault,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      match_cnt,
  output logic [WIDTH-1:0]      expected
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             err_inc, match_inc, match_clr;
  logic             soft_rst;
  logic [CNT_W-1:0] match_nxt;

  assign soft_rst = reset | clear;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    match_inc   = 1'b0;
    match_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // First sample only seeds the expectation; it can never be an error.
        if (smp.in_valid) begin
          expected_d = smp.in_data + WIDTH'(1);
          match_clr  = 1'b1;
          state_d    = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (smp.in_valid) begin
          if (smp.in_data == expected_q) begin
            expected_d = expected_q + WIDTH'(1);
            match_inc  = 1'b1;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            match_clr   = 1'b1;
            expected_d  = smp.in_data + WIDTH'(1);
            if (sat_inc(err_cnt) >= CNT_W'(MAX_ERR)) begin
              state_d = ST_FAULT;
            end
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Mirror of the match counter's next value so locked lines up with match_cnt.
  always_comb begin
    match_nxt = match_cnt;
    if (match_clr) begin
      match_nxt = '0;
    end else if (match_inc) begin
      match_nxt = sat_inc(match_cnt);
    end
    locked_d = (state_d == ST_TRACK) && (match_nxt >= CNT_W'(LOCK_N));
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q     <= ST_IDLE;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  sat_counter8 u_err_cnt (
    .clk   (clk),
    .rst_i (soft_rst),
    .clr_i (1'b0),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );

  sat_counter8 u_match_cnt (
    .clk   (clk),
    .rst_i (soft_rst),
    .clr_i (match_clr),
    .inc_i (match_inc),
    .cnt_o (match_cnt)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign fault     = (state_q == ST_FAULT);
  assign expected  = expected_q;

endmodule

// File: doc/seq_counter_checker.md
Name: seq_counter_checker

Overview:
- Receive-side checker for the free-running, increment-by-one counter stream that the team's benches generate.
- Samples a counter value whenever in_valid is high and verifies that each sample equals the previous sample plus one, modulo 2^WIDTH.
- Reports lock status, per-sample mismatch pulses, saturating error and match counts, and a sticky fault.
- Sits between a counter source (DUT or bench) and the bench scoreboard.

Parameters:
WIDTH, 32, bit width of the observed counter value
LOCK_N, 4, consecutive matches required before locked asserts (1..255)
MAX_ERR, 15, error count at which the block enters sticky FAULT (1..255)

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous soft clear, same effect as reset
in_valid  input  1  in_data holds a sample this cycle
in_data  input  WIDTH  sampled counter value
locked  output  1  block is in TRACK and match_cnt >= LOCK_N
err_pulse  output  1  one-cycle pulse per mismatched sample
fault  output  1  sticky; high while in FAULT
err_cnt  output  8  mismatch count, saturates at 255
match_cnt  output  8  consecutive-match count, saturates at 255
expected  output  WIDTH  next value the block expects

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high.
- Reset or clear, sampled high at a clock edge, sets state=IDLE and sets every output to 0, including expected.
- clear has priority over in_valid; a sample arriving in the same cycle is dropped.
- reset and clear are equivalent.
- States: IDLE, TRACK, FAULT. Encoding is 2 bits: IDLE=0, TRACK=1, FAULT=2.
- IDLE with in_valid: expected <= in_data+1, match_cnt <= 0, then go to TRACK. The first sample never counts as an error.
- TRACK with in_valid and in_data==expected:
  - expected <= expected+1
  - match_cnt increments, saturating at 255
  - stay in TRACK
- TRACK with in_valid and in_data!=expected:
  - err_pulse=1 on the next cycle
  - err_cnt increments, saturating at 255
  - match_cnt <= 0
  - resync with expected <= in_data+1
  - if the new err_cnt >= MAX_ERR, go to FAULT; otherwise stay in TRACK
- FAULT:
  - all in_valid samples are ignored
  - expected, match_cnt and err_cnt are frozen
  - fault=1 and locked=0
  - exit only via reset or clear
- in_valid low: no state change; err_pulse returns to 0.
- Wrap-around: the successor of all-ones is 0 and counts as a match. All arithmetic is modulo 2^WIDTH, with no carry out.
- Latency: every output is registered and reflects a sample one cycle after the edge at which that sample was captured.
- locked is a registered compare, valid in the same cycle as the updated match_cnt.
- Samples may arrive back-to-back on every cycle; there is no backpressure and no ready signal.
- Reset mid-stream: the next sample after reset re-enters via IDLE, so no error is flagged for the discontinuity.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/TRACK/FAULT)
  - counter width constant CNT_W=8
  - saturation limit 255
- One natural sub-module: sat_counter8, an 8-bit saturating counter with inc and synchronous clr inputs. It is instantiated twice, once for err_cnt and once for match_cnt.

Test Plan:
- Reset, then in_valid every cycle with 0..9 -> err_pulse never set; locked rises the cycle after the 5th sample (match_cnt=4); expected=10 at the end.
- Stream 100,101,102,200,201 -> single err_pulse after the 200 sample; err_cnt=1; match_cnt=0 then 1; expected=202.
- WIDTH=32 stream 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1 -> no errors; expected=2; match_cnt=3.
- With MAX_ERR=3, stream 5,9,13,17,18 -> err_cnt=3 and fault=1 after 17; the 18 sample is ignored; clear returns all outputs to 0 and the state to IDLE.
- clear and in_valid high together with in_data=7 -> sample dropped; next sample 50 with no error; expected=51.
- Gaps: samples 10,(idle 3 cycles),11,(idle),12 -> no errors; err_pulse stays 0 throughout.
